// File: rtl/adc_pkg.sv
// Shared types and widths for the ADC conversion/readout path.
// State encoding, ADC word width and channel index width.
package adc_pkg;

    localparam int ADC_W = 16;
    localparam int CH_W  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CONV_LOW,
        WAIT_BUSY_HI,
        WAIT_BUSY_LO,
        RD_LOW,
        RD_HIGH,
        PERIOD_WAIT
    } adc_rd_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
// Output is forced low while reset is asserted.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_conv_reader.sv
// Parallel-ADC conversion sequencer and word reader.
// Emits one valid strobe per channel word, frame_done on the last.
module adc_conv_reader
    import adc_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter logic [15:0] SAMPLE_PERIOD  = 16'd270,
    parameter int          CONVST_LOW_CYC = 2,
    parameter int          RD_LOW_CYC     = 2,
    parameter int          RD_HIGH_CYC    = 1,
    parameter logic [7:0]  BUSY_TIMEOUT   = 8'd200
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             busy,
    input  logic [ADC_W-1:0] db_in,
    input  logic             clear_err,
    output logic             convst,
    output logic             cs_n,
    output logic             rd_n,
    output logic [ADC_W-1:0] sample_data,
    output logic [CH_W-1:0]  sample_ch,
    output logic             sample_valid,
    output logic             frame_done,
    output logic             timeout_err,
    output logic             overrun_err
);

    localparam logic [7:0]      CONV_LAST = 8'(CONVST_LOW_CYC - 1);
    localparam logic [7:0]      RDL_LAST  = 8'(RD_LOW_CYC - 1);
    localparam logic [7:0]      RDH_LAST  = 8'(RD_HIGH_CYC - 1);
    localparam logic [7:0]      TMO_LAST  = BUSY_TIMEOUT - 8'd1;
    localparam logic [15:0]     PER_LAST  = SAMPLE_PERIOD - 16'd1;
    localparam logic [CH_W-1:0] LAST_CH   = CH_W'(NUM_CH - 1);

    adc_rd_state_t   state;
    adc_rd_state_t   state_n;
    logic [7:0]      tcnt;
    logic [15:0]     pcnt;
    logic [CH_W-1:0] ch;
    logic [CH_W-1:0] ch_n;
    logic            busy_s;
    logic            tmo;
    logic            ovr;
    logic            cap;

    sync_2ff u_busy_sync (
        .clk (clk),
        .rst (rst),
        .d   (busy),
        .q   (busy_s)
    );

    // Next-state, channel advance and timeout detection
    always_comb begin
        state_n = state;
        ch_n    = ch;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_n = CONV_LOW;
            end
            CONV_LOW: begin
                if (tcnt == CONV_LAST) state_n = WAIT_BUSY_HI;
            end
            WAIT_BUSY_HI: begin
                if (busy_s) begin
                    state_n = WAIT_BUSY_LO;
                end else if (tcnt == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = PERIOD_WAIT;
                end
            end
            WAIT_BUSY_LO: begin
                if (!busy_s) begin
                    state_n = RD_LOW;
                    ch_n    = '0;
                end else if (tcnt == TMO_LAST) begin
                    tmo     = 1'b1;
                    state_n = PERIOD_WAIT;
                end
            end
            RD_LOW: begin
                if (tcnt == RDL_LAST) state_n = RD_HIGH;
            end
            RD_HIGH: begin
                if (tcnt == RDH_LAST) begin
                    if (ch == LAST_CH) begin
                        state_n = PERIOD_WAIT;
                    end else begin
                        ch_n    = ch + 3'd1;
                        state_n = RD_LOW;
                    end
                end
            end
            PERIOD_WAIT: begin
                if (pcnt == PER_LAST) state_n = enable ? CONV_LOW : IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ovr = (state != IDLE) && (state != PERIOD_WAIT) && (pcnt == PER_LAST);
    assign cap = (state == RD_LOW) && (tcnt == RDL_LAST);

    // State, per-state timer and channel registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            tcnt  <= '0;
            ch    <= '0;
        end else begin
            state <= state_n;
            ch    <= ch_n;
            tcnt  <= (state_n != state) ? 8'd0 : tcnt + 8'd1;
        end
    end

    // Period counter: zeroed at each CONVST fall, saturates on overrun
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (state_n == CONV_LOW && state != CONV_LOW) begin
            pcnt <= '0;
        end else if (state == IDLE) begin
            pcnt <= '0;
        end else if (pcnt != PER_LAST) begin
            pcnt <= pcnt + 16'd1;
        end
    end

    // Registered ADC strobes, sample capture and sticky errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            convst       <= 1'b1;
            cs_n         <= 1'b1;
            rd_n         <= 1'b1;
            sample_data  <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            timeout_err  <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            convst       <= (state_n != CONV_LOW);
            cs_n         <= !(state_n == RD_LOW || state_n == RD_HIGH);
            rd_n         <= (state_n != RD_LOW);
            sample_valid <= cap;
            frame_done   <= cap && (ch == LAST_CH);
            if (cap) begin
                sample_data <= db_in;
                sample_ch   <= ch;
            end
            timeout_err  <= tmo | (timeout_err & ~clear_err);
            overrun_err  <= ovr | (overrun_err & ~clear_err);
        end
    end

endmodule
